vdp_sprite_vram_arbiter: RTL and testbench

//  Shares the single VRAM port between the sprite renderer's pattern fetches and host (CPU) VRAM reads/writes.
//  One access is granted per cycle. Grants are issued in a fixed pipeline, and read data is routed back to its owner.

---
 rtl/vdp_vram_arb_pkg.sv | 27 ++
 rtl/vdp_vram_return_pipe.sv | 53 +++++
 rtl/vdp_sprite_vram_arbiter.sv | 122 ++++++++++++
 tb/tb_vdp_sprite_vram_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_vram_arb_pkg.sv
// Shared owner codes, return-tag layout and nibble-reverse helper for the sprite/host VRAM arbiter.
package vdp_vram_arb_pkg;

  localparam int unsigned OWNER_WIDTH = 2;

  localparam logic [OWNER_WIDTH-1:0] OWNER_NONE   = 2'd0;
  localparam logic [OWNER_WIDTH-1:0] OWNER_SPRITE = 2'd1;
  localparam logic [OWNER_WIDTH-1:0] OWNER_HOST   = 2'd2;

  typedef struct packed {
    logic [OWNER_WIDTH-1:0] owner;
    logic                   x_flip;
  } ret_tag_t;

  localparam int unsigned TAG_WIDTH = $bits(ret_tag_t);

  // Reverses the order of the eight 4bpp pixels in a word (horizontal sprite flip).
  function automatic logic [31:0] nibble_reverse32(input logic [31:0] word);
    logic [31:0] rev;
    rev = '0;
    for (int k = 0; k < 8; k++) begin
      rev[4*k +: 4] = word[28-4*k +: 4];
    end
    return rev;
  endfunction

endpackage

// File: rtl/vdp_vram_return_pipe.sv
// Delays the {owner, x_flip} tag to line up with VRAM read data, then routes and flips it to its owner.
module vdp_vram_return_pipe
  import vdp_vram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned VRAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  input  logic [DATA_WIDTH-1:0] vram_read_data,
  output logic [DATA_WIDTH-1:0] sprite_data,
  output logic                  sprite_data_valid,
  output logic [DATA_WIDTH-1:0] host_read_data,
  output logic                  host_read_valid
);

  localparam int unsigned DEPTH = VRAM_LATENCY + 1;

  logic [DEPTH*TAG_WIDTH-1:0] pipe_q;
  ret_tag_t                   tail;

  assign tail = pipe_q[DEPTH*TAG_WIDTH-1 -: TAG_WIDTH];

  // Tag shift register; all-zero is OWNER_NONE so reset discards in-flight reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[(DEPTH-1)*TAG_WIDTH-1:0], tag_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sprite_data       <= '0;
      sprite_data_valid <= 1'b0;
      host_read_data    <= '0;
      host_read_valid   <= 1'b0;
    end else begin
      sprite_data_valid <= (tail.owner == OWNER_SPRITE);
      host_read_valid   <= (tail.owner == OWNER_HOST);
      if (tail.owner == OWNER_SPRITE) begin
        sprite_data <= tail.x_flip ? DATA_WIDTH'(nibble_reverse32(32'(vram_read_data)))
                                   : vram_read_data;
      end
      if (tail.owner == OWNER_HOST) begin
        host_read_data <= vram_read_data;
      end
    end
  end

endmodule

// File: rtl/vdp_sprite_vram_arbiter.sv
// Arbitrates the single VRAM port between sprite pattern fetches and host accesses.
// Optional host starvation guard: define VDP_VRAM_ARB_STARVE_GUARD_EN.
module vdp_sprite_vram_arbiter
  import vdp_vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 14,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned VRAM_LATENCY  = 1
`ifdef VDP_VRAM_ARB_STARVE_GUARD_EN
  ,
  parameter int unsigned MAX_HOST_WAIT = 8
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sprite_window,
  input  logic                  sprite_req,
  input  logic [ADDR_WIDTH-1:0] sprite_address,
  input  logic                  sprite_x_flip,
  output logic                  sprite_ack,
  output logic [DATA_WIDTH-1:0] sprite_data,
  output logic                  sprite_data_valid,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_address,
  input  logic [DATA_WIDTH-1:0] host_write_data,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_read_data,
  output logic                  host_read_valid,
  output logic [ADDR_WIDTH-1:0] vram_address,
  output logic                  vram_we,
  output logic [DATA_WIDTH-1:0] vram_write_data,
  input  logic [DATA_WIDTH-1:0] vram_read_data
);

  logic     host_force_c;
  logic     sprite_win_c;
  logic     host_win_c;
  ret_tag_t tag_c;

`ifdef VDP_VRAM_ARB_STARVE_GUARD_EN
  localparam int unsigned WAIT_WIDTH = $clog2(MAX_HOST_WAIT + 1);

  logic [WAIT_WIDTH-1:0] host_wait_q;

  // Consecutive cycles the host has been kept waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_wait_q <= '0;
    end else if (host_win_c) begin
      host_wait_q <= '0;
    end else if (host_req) begin
      host_wait_q <= host_wait_q + WAIT_WIDTH'(1);
    end
  end

  assign host_force_c = host_req && (host_wait_q == WAIT_WIDTH'(MAX_HOST_WAIT));
`else
  assign host_force_c = 1'b0;
`endif

  // Window priority; acks are suppressed while reset is held.
  always_comb begin
    sprite_win_c = 1'b0;
    host_win_c   = 1'b0;
    if (!reset) begin
      if (host_force_c) begin
        host_win_c = 1'b1;
      end else if (sprite_window) begin
        if (sprite_req)    sprite_win_c = 1'b1;
        else if (host_req) host_win_c   = 1'b1;
      end else begin
        if (host_req)        host_win_c   = 1'b1;
        else if (sprite_req) sprite_win_c = 1'b1;
      end
    end
  end

  assign sprite_ack = sprite_win_c;
  assign host_ack   = host_win_c;

  always_comb begin
    tag_c = '{owner: OWNER_NONE, x_flip: 1'b0};
    if (sprite_win_c) begin
      tag_c = '{owner: OWNER_SPRITE, x_flip: sprite_x_flip};
    end else if (host_win_c && !host_we) begin
      tag_c = '{owner: OWNER_HOST, x_flip: 1'b0};
    end
  end

  // VRAM command register; the address holds on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      vram_address    <= '0;
      vram_we         <= 1'b0;
      vram_write_data <= '0;
    end else begin
      vram_we <= host_win_c && host_we;
      if (sprite_win_c) begin
        vram_address <= sprite_address;
      end else if (host_win_c) begin
        vram_address    <= host_address;
        vram_write_data <= host_write_data;
      end
    end
  end

  vdp_vram_return_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .VRAM_LATENCY(VRAM_LATENCY)
  ) u_return_pipe (
    .clk              (clk),
    .reset            (reset),
    .tag_in           (tag_c),
    .vram_read_data   (vram_read_data),
    .sprite_data      (sprite_data),
    .sprite_data_valid(sprite_data_valid),
    .host_read_data   (host_read_data),
    .host_read_valid  (host_read_valid)
  );

endmodule

// File: tb/tb_vdp_sprite_vram_arbiter.sv
// Randomized scoreboard bench for vdp_sprite_vram_arbiter with a behavioural VRAM and reference model.
`timescale 1ns/1ps
module tb_vdp_sprite_vram_arbiter;

  localparam int unsigned AW   = 14;
  localparam int unsigned DW   = 32;
  localparam int          LAT  = 1;
  localparam int          MAXW = 8;
`ifdef VDP_VRAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sprite_window = 1'b1;
  logic          sprite_req = 1'b0;
  logic [AW-1:0] sprite_address = '0;
  logic          sprite_x_flip = 1'b0;
  logic          sprite_ack;
  logic [DW-1:0] sprite_data;
  logic          sprite_data_valid;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_address = '0;
  logic [DW-1:0] host_write_data = '0;
  logic          host_ack;
  logic [DW-1:0] host_read_data;
  logic          host_read_valid;
  logic [AW-1:0] vram_address;
  logic          vram_we;
  logic [DW-1:0] vram_write_data;
  logic [DW-1:0] vram_read_data = '0;

  vdp_sprite_vram_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .sprite_window    (sprite_window),
    .sprite_req       (sprite_req),
    .sprite_address   (sprite_address),
    .sprite_x_flip    (sprite_x_flip),
    .sprite_ack       (sprite_ack),
    .sprite_data      (sprite_data),
    .sprite_data_valid(sprite_data_valid),
    .host_req         (host_req),
    .host_we          (host_we),
    .host_address     (host_address),
    .host_write_data  (host_write_data),
    .host_ack         (host_ack),
    .host_read_data   (host_read_data),
    .host_read_valid  (host_read_valid),
    .vram_address     (vram_address),
    .vram_we          (vram_we),
    .vram_write_data  (vram_write_data),
    .vram_read_data   (vram_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } ret_t;

  logic [31:0] vmem   [16384];
  logic [31:0] refmem [16384];
  ret_t        sq[$];
  ret_t        hq[$];

  int          cyc = 0;
  bit          rst_q = 1'b0;
  int          ncmp = 0;
  int          nerr = 0;
  int          wait_cnt = 0;
  logic [AW-1:0] nv_addr = '0, cv_addr = '0;
  bit            nv_we = 1'b0, cv_we = 1'b0;
  logic [31:0]   nv_wd = '0, cv_wd = '0;
  logic [31:0]   exp_sdata = '0, exp_hdata = '0;

  bit            s_pend = 1'b0, s_f = 1'b0;
  logic [AW-1:0] s_a = '0;
  bit            h_pend = 1'b0, h_w = 1'b0;
  logic [AW-1:0] h_a = '0;
  logic [31:0]   h_d = '0;
  int            s_rate = 0, h_rate = 0;
  bit            win = 1'b1, rst_drv = 1'b1;

  // Pixel order reversal: last nibble of the input becomes the first of the output.
  function automatic logic [31:0] flip_pixels(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = (r << 4) | ((w >> (4 * k)) & 32'hF);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural VRAM: write applied, then read data returned one cycle later.
  always @(posedge clk) begin
    if (vram_we) vmem[vram_address] = vram_write_data;
    vram_read_data <= vmem[vram_address];
  end

  always @(posedge clk) begin
    cyc++;
    rst_q   = reset;
    cv_addr = nv_addr;
    cv_we   = nv_we;
    cv_wd   = nv_wd;
  end

  // Monitor: compares strobes, routed data and the VRAM command each cycle.
  always @(negedge clk) begin
    bit ev;
    if (rst_q) begin
      sq.delete();
      hq.delete();
      exp_sdata = '0;
      exp_hdata = '0;
    end
    ev = (sq.size() > 0) && (sq[0].due == cyc);
    check("sprite_data_valid", 32'(sprite_data_valid), 32'(ev));
    if (ev) begin
      exp_sdata = sq[0].data;
      void'(sq.pop_front());
    end
    check("sprite_data", sprite_data, exp_sdata);
    ev = (hq.size() > 0) && (hq[0].due == cyc);
    check("host_read_valid", 32'(host_read_valid), 32'(ev));
    if (ev) begin
      exp_hdata = hq[0].data;
      void'(hq.pop_front());
    end
    check("host_read_data", host_read_data, exp_hdata);
    check("vram_we", 32'(vram_we), 32'(cv_we));
    check("vram_address", 32'(vram_address), 32'(cv_addr));
    if (cv_we) check("vram_write_data", vram_write_data, cv_wd);
  end

  // One cycle of stimulus plus the reference arbitration decision.
  task automatic step();
    bit   g_s, g_h;
    ret_t e;
    @(negedge clk);
    if (!s_pend && ($urandom_range(99) < 32'(s_rate))) begin
      s_pend = 1'b1;
      s_a    = AW'($urandom_range(15));
      s_f    = 1'($urandom);
    end
    if (!h_pend && ($urandom_range(99) < 32'(h_rate))) begin
      h_pend = 1'b1;
      h_w    = 1'($urandom);
      h_a    = AW'($urandom_range(15));
      h_d    = $urandom;
    end
    reset           = rst_drv;
    sprite_window   = win;
    sprite_req      = s_pend;
    sprite_address  = s_a;
    sprite_x_flip   = s_f;
    host_req        = h_pend;
    host_we         = h_w;
    host_address    = h_a;
    host_write_data = h_d;
    #1;
    g_s = 1'b0;
    g_h = 1'b0;
    if (!rst_drv) begin
      if (GUARD && h_pend && wait_cnt == MAXW) g_h = 1'b1;
      else if (win) begin
        if (s_pend) g_s = 1'b1; else if (h_pend) g_h = 1'b1;
      end else begin
        if (h_pend) g_h = 1'b1; else if (s_pend) g_s = 1'b1;
      end
    end
    check("sprite_ack", 32'(sprite_ack), 32'(g_s));
    check("host_ack", 32'(host_ack), 32'(g_h));
    if (rst_drv) begin
      wait_cnt = 0;
      nv_addr  = '0;
      nv_we    = 1'b0;
      nv_wd    = '0;
    end else begin
      if (g_h) wait_cnt = 0;
      else if (h_pend) wait_cnt++;
      nv_we = 1'b0;
      if (g_s) begin
        nv_addr = s_a;
        e.due   = cyc + 2 + LAT;
        e.data  = s_f ? flip_pixels(refmem[s_a]) : refmem[s_a];
        sq.push_back(e);
        s_pend = 1'b0;
      end
      if (g_h) begin
        nv_addr = h_a;
        if (h_w) begin
          nv_we       = 1'b1;
          nv_wd       = h_d;
          refmem[h_a] = h_d;
        end else begin
          e.due  = cyc + 2 + LAT;
          e.data = refmem[h_a];
          hq.push_back(e);
        end
        h_pend = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      vmem[i]   = $urandom;
      refmem[i] = vmem[i];
    end
    vmem[32'h20]   = 32'h0123_4567;
    refmem[32'h20] = 32'h0123_4567;

    rst_drv = 1'b1;
    repeat (3) step();
    rst_drv = 1'b0;

    // Sprite and host contend inside the sprite window.
    win = 1'b1;
    s_pend = 1'b1; s_a = 14'h5; s_f = 1'b0;
    h_pend = 1'b1; h_w = 1'b0; h_a = 14'h6;
    repeat (6) step();

    // Host write then read of the same word outside the window.
    win = 1'b0;
    h_pend = 1'b1; h_w = 1'b1; h_a = 14'h10; h_d = 32'h1234_5678;
    step();
    h_pend = 1'b1; h_w = 1'b0; h_a = 14'h10;
    repeat (6) step();

    // Flipped and unflipped fetch of a known word.
    win = 1'b1;
    s_pend = 1'b1; s_a = 14'h20; s_f = 1'b1;
    step();
    s_pend = 1'b1; s_a = 14'h20; s_f = 1'b0;
    repeat (6) step();

    // Back-to-back sprite fetches.
    s_rate = 100;
    repeat (20) step();
    s_rate = 0;
    repeat (5) step();

    // Reset one cycle after a sprite grant.
    s_pend = 1'b1; s_a = 14'h3; s_f = 1'b0;
    step();
    rst_drv = 1'b1;
    repeat (2) step();
    rst_drv = 1'b0;
    repeat (6) step();

    // Host held against continuous sprite traffic in the window.
    win = 1'b1; s_rate = 100;
    h_pend = 1'b1; h_w = 1'b0; h_a = 14'h7;
    repeat (12) step();
    win = 1'b0; s_rate = 0;
    repeat (6) step();

    // Randomized traffic with window toggles and occasional resets.
    for (int blk = 0; blk < 40; blk++) begin
      win    = 1'($urandom);
      s_rate = int'($urandom_range(100));
      h_rate = int'($urandom_range(100));
      for (int c = 0; c < 50; c++) begin
        rst_drv = ($urandom_range(199) == 0);
        step();
      end
    end
    rst_drv = 1'b0; s_rate = 0; h_rate = 0; win = 1'b0;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
